// File: rtl/imm_extend_shift_unit.sv
// Immediate/offset generator: extends a raw instruction field, then shifts it one bit per clock
// (logical left or arithmetic right) and hands the result out over a valid/ready handshake.
module imm_extend_shift_unit #(
  parameter int unsigned IN_WIDTH    = 12,
  parameter int unsigned MID_WIDTH   = 8,
  parameter int unsigned MIN_WIDTH   = 4,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHAMT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    data_in,
  input  logic [1:0]             mode,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   ovf
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0]   ext_val;

  always_comb begin
    ext_val = '0;
    unique case (mode)
      2'b00:   ext_val = {{(OUT_WIDTH-MIN_WIDTH){data_in[MIN_WIDTH-1]}}, data_in[MIN_WIDTH-1:0]};
      2'b01:   ext_val = {{(OUT_WIDTH-MID_WIDTH){data_in[MID_WIDTH-1]}}, data_in[MID_WIDTH-1:0]};
      2'b10:   ext_val = {{(OUT_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
      default: ext_val = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, data_in};
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = ext_val;
          cnt_d   = shamt;
          dir_d   = dir;
          ovf_d   = 1'b0;
          state_d = (shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (dir_q) begin
          acc_d = {acc_q[OUT_WIDTH-1], acc_q[OUT_WIDTH-1:1]};
        end else begin
          acc_d = {acc_q[OUT_WIDTH-2:0], 1'b0};
          // Sign change on this step: the two top bits differ before shifting.
          if (acc_q[OUT_WIDTH-1] != acc_q[OUT_WIDTH-2]) ovf_d = 1'b1;
        end
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign data_out  = acc_q;
  assign ovf       = ovf_q;

endmodule
